tfc_light_monitor: RTL and testbench
====================================

Name: tfc_light_monitor

Overview:
- Passive checker on the receiving end of the traffic-light controller's four one-hot lamp buses (mainRoad, mainRoad2, mainRoadTurn, sideTurn).
- Decodes the lamp pattern back into a phase index, checks phase order and per-phase dwell time, and latches a sticky fault with a code.
- Sits beside the controller in the top level and also serves as the bench scoreboard; it drives no lamps.

Parameters:
- DW_P1, 8, required dwell of phase 1 in clocks
- DW_P2, 3, required dwell of phase 2 in clocks
- DW_P3, 6, required dwell of phase 3 in clocks
- DW_P4, 3, required dwell of phase 4 in clocks
- DW_P5, 4, required dwell of phase 5 in clocks
- DW_P6, 3, required dwell of phase 6 in clocks
- CYC_W, 8, width of the completed-cycle counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mainRoad  in  3  lamp code, main road
- mainRoad2  in  3  lamp code, main road 2
- mainRoadTurn  in  3  lamp code, main-road turn
- sideTurn  in  3  lamp code, side turn
- clr  in  1  clears sticky fault and returns to IDLE; same effect as rst
- phase  out  3  decoded current phase: 1..6, 0 = dark or illegal
- in_sync  out  1  monitor is in TRACK
- fault  out  1  sticky fault flag
- fault_code  out  3  first fault cause: 0 none, 1 illegal pattern, 2 dark after sync, 3 sequence, 4 dwell short, 5 dwell overrun
- cycles_done  out  CYC_W  count of completed P6->P1 wraps; saturates at all-ones

Behaviour:
- Lamp encoding: 001 green, 010 yellow, 100 red, 000 dark.
- Legal patterns, in the order (mainRoad, mainRoad2, mainRoadTurn, sideTurn):
  - P1 = G,G,R,R
  - P2 = G,Y,R,R
  - P3 = G,R,G,R
  - P4 = Y,R,Y,R
  - P5 = R,R,R,G
  - P6 = R,R,R,Y
  - All-dark is classified "dark". Anything else is "illegal".
- Reset (rst or clr sampled high at a clk edge):
  - Outputs: phase=0, in_sync=0, fault=0, fault_code=0, cycles_done=0.
  - Internal: state=IDLE, dwell_cnt=0, prev_phase=0.
  - rst takes priority over every other event.
- Latency: all outputs are registered. A pattern present before edge k is reflected in phase, and any fault it causes, after edge k.
- States:
  - IDLE: dark is allowed and does not advance. Illegal pattern -> FAULT, code 1. P2..P6 ignored; in_sync stays 0. First P1 sample -> TRACK with dwell_cnt=1 and the initial-P1 dwell check suppressed.
  - TRACK, pattern unchanged: dwell_cnt increments. If dwell_cnt would exceed the required dwell of the current phase -> FAULT, code 5, on that same edge.
  - TRACK, pattern changed to a legal phase: the new phase must equal prev+1, with 6 wrapping to 1, otherwise code 3. If the order is correct, the old phase's dwell_cnt must equal its DW_Px, otherwise code 4. Exception: the first P1 after sync is exempt from the dwell check.
  - TRACK, on a 6->1 transition with no fault: cycles_done increments, saturating. dwell_cnt then restarts at 1.
  - TRACK, illegal pattern -> code 1. Dark -> code 2.
  - FAULT: fault=1; fault_code holds the first cause. phase keeps tracking the decode; in_sync=0 and cycles_done is frozen. Exit only via rst or clr.
- Simultaneous causes on one edge are resolved by priority 1 > 2 > 3 > 4 > 5; only the highest is recorded.
- dwell_cnt is wide enough to hold max(DW_Px)+1 and never wraps.

Decomposition:
- Package tfc_pkg holds:
  - lamp constants LAMP_G, LAMP_Y, LAMP_R, LAMP_OFF
  - phase enum PH_NONE, PH1..PH6
  - fault-code enum
  - the six legal pattern constants (12 bits each)
- The controller shares this package.
- Sub-module tfc_phase_decode: combinational, 4x3-bit lamp codes in; phase index, is_dark and is_illegal out. It is reused by the controller's assertions.

Test Plan:
- Nominal: rst high 2 clocks, then drive two full cycles with dwells 8/3/6/3/4/3 -> fault=0, in_sync=1 from the first P1 sample, phase steps 1..6, cycles_done=2.
- Illegal: in TRACK during P3, drive mainRoad=011 for one clock -> next edge fault=1, fault_code=1; a later return to legal patterns keeps fault=1.
- Skipped phase: after a P2 dwell of 3 clocks, drive P4 -> fault_code=3, not 4.
- Short and stuck dwell:
  - P5 held only 3 clocks, then P6 -> fault_code=4.
  - Separate run: P6 held a 4th clock -> fault_code=5 on that 4th edge.
- Dark and sync:
  - All-dark during IDLE for 10 clocks, then P1 -> no fault, in_sync=1.
  - Dark injected in TRACK -> fault_code=2.
- Reset and clear:
  - clr pulsed in FAULT -> fault=0, IDLE; in_sync=0 until the next P1.
  - rst asserted mid-P3 -> all outputs 0 next edge, cycles_done=0.
  - cycles_done at 255 with CYC_W=8 stays 255 after another wrap.

Source files
------------

// File: rtl/tfc_pkg.sv
// tfc_pkg: shared definitions for the traffic-light controller and its monitor.
//   - lamp codes (one-hot per lamp bus, 000 = dark)
//   - phase index, fault-code and monitor-state enums
//   - the six legal 12-bit lamp patterns {mainRoad, mainRoad2, mainRoadTurn, sideTurn}
//   - small helpers: phase successor and integer max
package tfc_pkg;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;

    typedef enum logic [2:0] {
        PH_NONE = 3'd0,
        PH1     = 3'd1,
        PH2     = 3'd2,
        PH3     = 3'd3,
        PH4     = 3'd4,
        PH5     = 3'd5,
        PH6     = 3'd6
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE    = 3'd0,
        FC_ILLEGAL = 3'd1,
        FC_DARK    = 3'd2,
        FC_SEQ     = 3'd3,
        FC_SHORT   = 3'd4,
        FC_OVERRUN = 3'd5
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_e;

    localparam logic [11:0] PAT_P1 = {LAMP_G, LAMP_G, LAMP_R, LAMP_R};
    localparam logic [11:0] PAT_P2 = {LAMP_G, LAMP_Y, LAMP_R, LAMP_R};
    localparam logic [11:0] PAT_P3 = {LAMP_G, LAMP_R, LAMP_G, LAMP_R};
    localparam logic [11:0] PAT_P4 = {LAMP_Y, LAMP_R, LAMP_Y, LAMP_R};
    localparam logic [11:0] PAT_P5 = {LAMP_R, LAMP_R, LAMP_R, LAMP_G};
    localparam logic [11:0] PAT_P6 = {LAMP_R, LAMP_R, LAMP_R, LAMP_Y};
    localparam logic [11:0] PAT_DARK = {LAMP_OFF, LAMP_OFF, LAMP_OFF, LAMP_OFF};

    // Legal successor of a phase; P6 wraps back to P1.
    function automatic phase_e next_phase(input phase_e p);
        logic [2:0] raw;
        raw = p;
        if (p == PH6) return PH1;
        return phase_e'(raw + 3'd1);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tfc_phase_decode.sv
// tfc_phase_decode: combinational lamp-pattern classifier.
//   in : lamp_main, lamp_main2, lamp_turn, lamp_side - 3-bit lamp codes
//   out: phase      - PH1..PH6 for a legal pattern, PH_NONE otherwise
//        is_dark    - every lamp off
//        is_illegal - neither a legal phase nor dark
module tfc_phase_decode
    import tfc_pkg::*;
(
    input  logic [2:0] lamp_main,
    input  logic [2:0] lamp_main2,
    input  logic [2:0] lamp_turn,
    input  logic [2:0] lamp_side,
    output phase_e     phase,
    output logic       is_dark,
    output logic       is_illegal
);

    logic [11:0] pat;

    always_comb begin
        pat        = {lamp_main, lamp_main2, lamp_turn, lamp_side};
        phase      = PH_NONE;
        is_dark    = 1'b0;
        is_illegal = 1'b0;
        case (pat)
            PAT_P1:   phase = PH1;
            PAT_P2:   phase = PH2;
            PAT_P3:   phase = PH3;
            PAT_P4:   phase = PH4;
            PAT_P5:   phase = PH5;
            PAT_P6:   phase = PH6;
            PAT_DARK: is_dark = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/tfc_light_monitor.sv
// tfc_light_monitor: passive checker of the traffic-light lamp buses.
//   clk, rst          - clock, synchronous active-high reset
//   mainRoad, mainRoad2, mainRoadTurn, sideTurn - 3-bit lamp codes
//   clr               - clears the sticky fault and returns to IDLE (same as rst)
//   phase             - registered decode of the lamp pattern (0 = dark/illegal)
//   in_sync           - monitor is tracking the phase sequence
//   fault, fault_code - sticky fault flag and the first cause
//   cycles_done       - completed P6->P1 wraps, saturating
module tfc_light_monitor
    import tfc_pkg::*;
#(
    parameter int DW_P1 = 8,
    parameter int DW_P2 = 3,
    parameter int DW_P3 = 6,
    parameter int DW_P4 = 3,
    parameter int DW_P5 = 4,
    parameter int DW_P6 = 3,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mainRoad,
    input  logic [2:0]       mainRoad2,
    input  logic [2:0]       mainRoadTurn,
    input  logic [2:0]       sideTurn,
    input  logic             clr,
    output logic [2:0]       phase,
    output logic             in_sync,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CYC_W-1:0] cycles_done
);

    localparam int DW_MAX = imax(imax(imax(DW_P1, DW_P2), imax(DW_P3, DW_P4)),
                                 imax(DW_P5, DW_P6));
    // Room for DW_MAX+1 so the counter can never wrap.
    localparam int CNT_W  = $clog2(DW_MAX + 2);

    function automatic logic [CNT_W-1:0] dwell_req(input phase_e p);
        case (p)
            PH1:     return CNT_W'(DW_P1);
            PH2:     return CNT_W'(DW_P2);
            PH3:     return CNT_W'(DW_P3);
            PH4:     return CNT_W'(DW_P4);
            PH5:     return CNT_W'(DW_P5);
            PH6:     return CNT_W'(DW_P6);
            default: return '0;
        endcase
    endfunction

    phase_e dec_phase;
    logic   dec_dark;
    logic   dec_illegal;

    tfc_phase_decode u_decode (
        .lamp_main  (mainRoad),
        .lamp_main2 (mainRoad2),
        .lamp_turn  (mainRoadTurn),
        .lamp_side  (sideTurn),
        .phase      (dec_phase),
        .is_dark    (dec_dark),
        .is_illegal (dec_illegal)
    );

    mon_state_e         state_q, state_d;
    phase_e             phase_q, phase_d;   // also serves as the previous phase in TRACK
    logic [CNT_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    fault_code_e        code_q, code_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    // Set while still in the P1 that brought us into sync: the monitor may
    // have started mid-phase, so that P1's length is not checked for shortness.
    logic               first_q, first_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_NONE;
            dwell_cnt_q <= '0;
            code_q      <= FC_NONE;
            cyc_q       <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            dwell_cnt_q <= dwell_cnt_d;
            code_q      <= code_d;
            cyc_q       <= cyc_d;
            first_q     <= first_d;
        end
    end

    // Next-state logic
    always_comb begin
        fault_code_e cause;
        state_d     = state_q;
        phase_d     = dec_phase;
        dwell_cnt_d = dwell_cnt_q;
        code_d      = code_q;
        cyc_d       = cyc_q;
        first_d     = first_q;
        cause       = FC_NONE;

        case (state_q)
            ST_IDLE: begin
                if (dec_illegal) begin
                    state_d = ST_FAULT;
                    code_d  = FC_ILLEGAL;
                end else if (dec_phase == PH1) begin
                    state_d     = ST_TRACK;
                    dwell_cnt_d = CNT_W'(1);
                    first_d     = 1'b1;
                end
            end

            ST_TRACK: begin
                // Checks ordered by fault priority; the first hit wins.
                if (dec_illegal) begin
                    cause = FC_ILLEGAL;
                end else if (dec_dark) begin
                    cause = FC_DARK;
                end else if (dec_phase != phase_q) begin
                    if (dec_phase != next_phase(phase_q)) begin
                        cause = FC_SEQ;
                    end else if (!first_q && dwell_cnt_q != dwell_req(phase_q)) begin
                        cause = FC_SHORT;
                    end else begin
                        dwell_cnt_d = CNT_W'(1);
                        first_d     = 1'b0;
                        if (phase_q == PH6 && cyc_q != '1) cyc_d = cyc_q + 1'b1;
                    end
                end else if (dwell_cnt_q >= dwell_req(phase_q)) begin
                    cause = FC_OVERRUN;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end

                if (cause != FC_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = cause;
                end
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs, all from flops
    always_comb begin
        phase       = phase_q;
        in_sync     = (state_q == ST_TRACK);
        fault       = (state_q == ST_FAULT);
        fault_code  = code_q;
        cycles_done = cyc_q;
    end

endmodule

// File: tb/tb_tfc_light_monitor.sv
module tb_tfc_light_monitor;

    logic       clk = 1'b0;
    logic       rst, clr;
    logic [2:0] mr, mr2, mt, st;
    logic [2:0] phase;
    logic       in_sync, fault;
    logic [2:0] fault_code;
    logic [7:0] cycles_done;

    int tests = 0;
    int fails = 0;

    tfc_light_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .mainRoad     (mr),
        .mainRoad2    (mr2),
        .mainRoadTurn (mt),
        .sideTurn     (st),
        .clr          (clr),
        .phase        (phase),
        .in_sync      (in_sync),
        .fault        (fault),
        .fault_code   (fault_code),
        .cycles_done  (cycles_done)
    );

    always #5 clk = ~clk;

    int dw[7] = '{0, 8, 3, 6, 3, 4, 3};

    function automatic logic [11:0] pat(input int p);
        case (p)
            1: return 12'b001_001_100_100;
            2: return 12'b001_010_100_100;
            3: return 12'b001_100_001_100;
            4: return 12'b010_100_010_100;
            5: return 12'b100_100_100_001;
            6: return 12'b100_100_100_010;
            default: return 12'b0;
        endcase
    endfunction

    // 1..6 legal phase, 0 dark, 7 illegal
    function automatic int classify(input logic [11:0] x);
        for (int p = 1; p <= 6; p++) if (x == pat(p)) return p;
        if (x == 12'b0) return 0;
        return 7;
    endfunction

    // Reference model: mode 0 idle, 1 tracking, 2 faulted
    int m_mode, m_phase, m_cnt, m_code, m_cyc;
    bit m_first, armed = 0;

    task automatic m_fault(input int c);
        m_mode = 2;
        m_code = c;
    endtask

    always @(posedge clk) begin
        int d;
        d = classify({mr, mr2, mt, st});
        if (rst || clr) begin
            m_mode = 0; m_phase = 0; m_cnt = 0; m_code = 0; m_cyc = 0; m_first = 0;
            armed = 1;
        end else begin
            if (m_mode == 0) begin
                if (d == 7) m_fault(1);
                else if (d == 1) begin m_mode = 1; m_cnt = 1; m_first = 1; end
            end else if (m_mode == 1) begin
                if (d == 7) m_fault(1);
                else if (d == 0) m_fault(2);
                else if (d == m_phase) begin
                    if (m_cnt + 1 > dw[d]) m_fault(5);
                    else m_cnt++;
                end else if (d != m_phase % 6 + 1) m_fault(3);
                else if (!m_first && m_cnt != dw[m_phase]) m_fault(4);
                else begin
                    if (m_phase == 6 && m_cyc < 255) m_cyc++;
                    m_cnt = 1;
                    m_first = 0;
                end
            end
            m_phase = (d == 7) ? 0 : d;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            tests++;
            if (phase !== 3'(m_phase) || in_sync !== (m_mode == 1) || fault !== (m_mode == 2) ||
                fault_code !== 3'(m_code) || cycles_done !== 8'(m_cyc)) begin
                fails++;
                $display("FAIL model t=%0t phase=%0d/%0d in_sync=%0b/%0b fault=%0b/%0b code=%0d/%0d cycles=%0d/%0d",
                         $time, phase, m_phase, in_sync, m_mode == 1, fault, m_mode == 2,
                         fault_code, m_code, cycles_done, m_cyc);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic seg(input logic [11:0] p, input int n);
        {mr, mr2, mt, st} = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic rest_of_cycle();
        seg(pat(2), 3); seg(pat(3), 6); seg(pat(4), 3); seg(pat(5), 4); seg(pat(6), 3);
    endtask

    task automatic full_cycle();
        seg(pat(1), 8);
        rest_of_cycle();
    endtask

    task automatic pulse_clr();
        clr = 1'b1; seg(12'b0, 1); clr = 1'b0;
    endtask

    initial begin
        logic [11:0] tmp;
        int cur, r, p, n;
        rst = 1'b1; clr = 1'b0; {mr, mr2, mt, st} = 12'b0;
        seg(12'b0, 2);
        rst = 1'b0;
        chk("reset_phase", phase, 0);
        chk("reset_in_sync", in_sync, 0);
        chk("reset_fault", fault, 0);
        chk("reset_code", fault_code, 0);
        chk("reset_cycles", cycles_done, 0);

        // Nominal: two full wraps
        seg(pat(1), 1);
        chk("sync_first_p1", in_sync, 1);
        chk("sync_phase", phase, 1);
        seg(pat(1), 7); rest_of_cycle();
        full_cycle();
        seg(pat(1), 1);
        chk("nominal_cycles", cycles_done, 2);
        chk("nominal_fault", fault, 0);

        // Illegal pattern during P3
        seg(pat(1), 7); seg(pat(2), 3); seg(pat(3), 2);
        tmp = pat(3); tmp[11:9] = 3'b011;
        seg(tmp, 1);
        chk("illegal_fault", fault, 1);
        chk("illegal_code", fault_code, 1);
        seg(pat(3), 3); seg(pat(4), 3);
        chk("illegal_sticky", fault, 1);
        chk("illegal_sticky_code", fault_code, 1);

        // clr leaves FAULT; P2 in IDLE is ignored
        pulse_clr();
        chk("clr_fault", fault, 0);
        chk("clr_in_sync", in_sync, 0);
        seg(pat(2), 2);
        chk("idle_ignores_p2", in_sync, 0);

        // Skipped phase
        seg(pat(1), 8); seg(pat(2), 3); seg(pat(4), 1);
        chk("skip_code", fault_code, 3);
        pulse_clr();

        // Short P5
        seg(pat(1), 8); seg(pat(2), 3); seg(pat(3), 6); seg(pat(4), 3); seg(pat(5), 3); seg(pat(6), 1);
        chk("short_code", fault_code, 4);
        pulse_clr();

        // Overrun P6
        full_cycle();
        chk("p6_full_no_fault", fault, 0);
        seg(pat(6), 1);
        chk("overrun_code", fault_code, 5);
        pulse_clr();

        // Dark in IDLE, then dark in TRACK
        seg(12'b0, 10);
        chk("dark_idle_fault", fault, 0);
        seg(pat(1), 1);
        chk("dark_idle_sync", in_sync, 1);
        seg(12'b0, 1);
        chk("dark_track_code", fault_code, 2);
        pulse_clr();

        // rst mid-P3
        full_cycle(); seg(pat(1), 8); seg(pat(2), 3); seg(pat(3), 3);
        chk("pre_rst_cycles", cycles_done, 1);
        rst = 1'b1; seg(pat(3), 1); rst = 1'b0;
        chk("rst_phase", phase, 0);
        chk("rst_in_sync", in_sync, 0);
        chk("rst_cycles", cycles_done, 0);

        // Saturation
        repeat (255) full_cycle();
        seg(pat(1), 1);
        chk("sat_255", cycles_done, 255);
        seg(pat(1), 7); rest_of_cycle(); seg(pat(1), 1);
        chk("sat_hold", cycles_done, 255);
        chk("sat_no_fault", fault, 0);

        // Randomized traffic with perturbations
        pulse_clr();
        cur = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                pulse_clr(); cur = 0;
            end else if (r < 6) begin
                rst = 1'b1; seg(12'b0, 1); rst = 1'b0; cur = 0;
            end else if (r < 10) begin
                seg(12'($urandom), 1);
            end else if (r < 12) begin
                seg(12'b0, $urandom_range(1, 3));
            end else begin
                p = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : cur % 6 + 1;
                n = ($urandom_range(0, 5) == 0) ? $urandom_range(1, dw[p] + 1) : dw[p];
                seg(pat(p), n);
                cur = p;
            end
            if (m_mode == 2 && $urandom_range(0, 1) == 0) begin
                pulse_clr(); cur = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
